// File: rtl/exwb_pkg.sv
// Shared types for the execute-to-writeback arbiter.
// Entry layout, source ids and the round-robin successor helper.
package exwb_pkg;

    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;
    localparam logic [TAG_W-1:0] TAG_INVALID = '1;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_FWD = 2'd1,
        SRC_JMP = 2'd2
    } src_e;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
        logic              is_jump;
        logic [DATA_W-1:0] next_pc;
    } wb_entry_t;

    localparam wb_entry_t WB_IDLE = '{
        tag:     TAG_INVALID,
        value:   '0,
        is_jump: 1'b0,
        next_pc: '0
    };

    function automatic src_e next_src(src_e s);
        unique case (s)
            SRC_ALU: return SRC_FWD;
            SRC_FWD: return SRC_JMP;
            default: return SRC_ALU;
        endcase
    endfunction

endpackage

// File: rtl/exwb_if.sv
// Execute-side results, stall feedback and writeback bus.
// master drives results/flush; slave is the arbiter.
interface exwb_if;
    import exwb_pkg::*;

    logic              flush;
    logic [TAG_W-1:0]  alu_target;
    logic [DATA_W-1:0] alu_result;
    logic [TAG_W-1:0]  fwd_target;
    logic [DATA_W-1:0] fwd_result;
    logic [TAG_W-1:0]  jmp_target;
    logic [DATA_W-1:0] jmp_ori_pc;
    logic [DATA_W-1:0] jmp_next_pc;

    logic              alu_stall;
    logic              fwd_stall;
    logic              jmp_stall;
    logic              wb_valid;
    logic [TAG_W-1:0]  wb_tag;
    logic [DATA_W-1:0] wb_value;
    logic              wb_is_jump;
    logic [DATA_W-1:0] wb_next_pc;
    logic              overflow;

    modport master (
        output flush, alu_target, alu_result, fwd_target, fwd_result,
        output jmp_target, jmp_ori_pc, jmp_next_pc,
        input  alu_stall, fwd_stall, jmp_stall, wb_valid, wb_tag,
        input  wb_value, wb_is_jump, wb_next_pc, overflow
    );

    modport slave (
        input  flush, alu_target, alu_result, fwd_target, fwd_result,
        input  jmp_target, jmp_ori_pc, jmp_next_pc,
        output alu_stall, fwd_stall, jmp_stall, wb_valid, wb_tag,
        output wb_value, wb_is_jump, wb_next_pc, overflow
    );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO; a push at full is accepted only
// when a pop frees a slot in the same cycle, else it drops.
module wb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          wr;
    logic          rd;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign rd    = pop && !empty;
    assign wr    = push && (!full || rd);
    assign drop  = push && full && !rd;
    assign dout  = mem[rptr];

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) begin
                wptr <= wptr + AW'(1);
            end
            if (rd) begin
                rptr <= rptr + AW'(1);
            end
            count <= count + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end

endmodule

// File: rtl/exwb_arbiter.sv
// Writeback stage: per-source FIFOs, round-robin pick,
// registered writeback bus snooped by ROB and RS.
module exwb_arbiter
    import exwb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    exwb_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = $bits(wb_entry_t);

    wb_entry_t   in_e [3];
    wb_entry_t   head [3];
    logic [CW-1:0] cnt [3];
    logic [2:0]  push;
    logic [2:0]  pop;
    logic [2:0]  empty;
    logic [2:0]  full;
    logic [2:0]  drop;

    src_e        ptr;
    src_e        ptr_nxt;
    src_e        win;
    src_e        s;
    logic        found;
    logic        valid_q;
    wb_entry_t   wb_q;
    logic        ovf_q;

    always_comb begin
        in_e[0] = '{tag: bus.alu_target, value: bus.alu_result,
                    is_jump: 1'b0, next_pc: '0};
        in_e[1] = '{tag: bus.fwd_target, value: bus.fwd_result,
                    is_jump: 1'b0, next_pc: '0};
        // Jumps write back the link value, not the raw PC
        in_e[2] = '{tag: bus.jmp_target,
                    value: bus.jmp_ori_pc + DATA_W'(4),
                    is_jump: 1'b1, next_pc: bus.jmp_next_pc};
        push[0] = (bus.alu_target != TAG_INVALID);
        push[1] = (bus.fwd_target != TAG_INVALID);
        push[2] = (bus.jmp_target != TAG_INVALID);
    end

    for (genvar g = 0; g < 3; g++) begin : g_fifo
        wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (bus.flush),
            .push  (push[g]),
            .pop   (pop[g]),
            .din   (in_e[g]),
            .dout  (head[g]),
            .count (cnt[g]),
            .empty (empty[g]),
            .full  (full[g]),
            .drop  (drop[g])
        );
    end

    assign bus.alu_stall = (cnt[0] >= CW'(DEPTH - 1));
    assign bus.fwd_stall = (cnt[1] >= CW'(DEPTH - 1));
    assign bus.jmp_stall = (cnt[2] >= CW'(DEPTH - 1));

    always_comb begin
        found   = 1'b0;
        win     = ptr;
        s       = ptr;
        pop     = '0;
        for (int i = 0; i < 3; i++) begin
            if (!found && !empty[s]) begin
                found = 1'b1;
                win   = s;
            end
            s = next_src(s);
        end
        if (found) begin
            pop[win] = 1'b1;
        end
        ptr_nxt = found ? next_src(win) : ptr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= SRC_ALU;
            valid_q <= 1'b0;
            wb_q    <= WB_IDLE;
            ovf_q   <= 1'b0;
        end else if (bus.flush) begin
            ptr     <= SRC_ALU;
            valid_q <= 1'b0;
            wb_q    <= WB_IDLE;
        end else begin
            ptr     <= ptr_nxt;
            valid_q <= found;
            wb_q    <= found ? head[win] : WB_IDLE;
            if (|drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.wb_valid   = valid_q;
    assign bus.wb_tag     = wb_q.tag;
    assign bus.wb_value   = wb_q.value;
    assign bus.wb_is_jump = wb_q.is_jump;
    assign bus.wb_next_pc = wb_q.next_pc;
    assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_exwb_arbiter.sv
// Scoreboard bench for exwb_arbiter: directed stimulus pushes
// hand-computed writebacks; a negedge monitor pops and compares.
module tb_exwb_arbiter;
    import exwb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    bit   mon_en = 1'b0;
    int   vectors = 0;
    int   errors = 0;
    wb_entry_t expq[$];

    always #5 clk = ~clk;

    exwb_if bus ();

    exwb_arbiter #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [79:0] act,
                         input logic [79:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic wb_entry_t mk(input logic [3:0] t,
                                     input logic [31:0] v,
                                     input logic j,
                                     input logic [31:0] n);
        wb_entry_t e;
        e.tag = t;
        e.value = v;
        e.is_jump = j;
        e.next_pc = n;
        return e;
    endfunction

    always @(negedge clk) begin
        wb_entry_t e;
        if (mon_en) begin
            if (bus.wb_valid === 1'b1) begin
                if (expq.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_wb: got tag %0h expected none",
                             bus.wb_tag);
                end else begin
                    e = expq.pop_front();
                    check("wb_tag", 80'(bus.wb_tag), 80'(e.tag));
                    check("wb_value", 80'(bus.wb_value), 80'(e.value));
                    check("wb_is_jump", 80'(bus.wb_is_jump), 80'(e.is_jump));
                    check("wb_next_pc", 80'(bus.wb_next_pc), 80'(e.next_pc));
                end
            end else begin
                check("idle_bus",
                      80'({bus.wb_valid, bus.wb_tag, bus.wb_value,
                           bus.wb_is_jump, bus.wb_next_pc}),
                      80'({1'b0, WB_IDLE}));
            end
        end
    end

    task automatic idle();
        bus.flush = 1'b0;
        bus.alu_target = TAG_INVALID;
        bus.alu_result = '0;
        bus.fwd_target = TAG_INVALID;
        bus.fwd_result = '0;
        bus.jmp_target = TAG_INVALID;
        bus.jmp_ori_pc = '0;
        bus.jmp_next_pc = '0;
    endtask

    task automatic cyc(input logic [3:0] at, input logic [31:0] av,
                       input logic [3:0] ft, input logic [31:0] fv,
                       input logic [3:0] jt, input logic [31:0] jo,
                       input logic [31:0] jn, input logic fl);
        bus.alu_target = at;
        bus.alu_result = av;
        bus.fwd_target = ft;
        bus.fwd_result = fv;
        bus.jmp_target = jt;
        bus.jmp_ori_pc = jo;
        bus.jmp_next_pc = jn;
        bus.flush = fl;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_flush();
        cyc(TAG_INVALID, 0, TAG_INVALID, 0, TAG_INVALID, 0, 0, 1'b1);
    endtask

    task automatic drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (expq.size() == 0 && bus.wb_valid === 1'b0) done = 1'b1;
        end
        vectors++;
        if (!done) begin
            errors++;
            $display("FAIL %s: got %0d pending expected 0", name, expq.size());
        end
    endtask

    task automatic check_outs_reset(input string name);
        check({name, "_valid"}, 80'(bus.wb_valid), 80'(0));
        check({name, "_tag"}, 80'(bus.wb_tag), 80'(4'hF));
        check({name, "_value"}, 80'(bus.wb_value), 80'(0));
        check({name, "_jump"}, 80'(bus.wb_is_jump), 80'(0));
        check({name, "_npc"}, 80'(bus.wb_next_pc), 80'(0));
        check({name, "_stalls"},
              80'({bus.alu_stall, bus.fwd_stall, bus.jmp_stall}), 80'(0));
        check({name, "_ovf"}, 80'(bus.overflow), 80'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_outs_reset("reset");
        mon_en = 1'b1;

        // single ALU result, two-cycle latency
        expq.push_back(mk(4'd3, 32'h1234, 1'b0, 32'h0));
        cyc(4'd3, 32'h1234, TAG_INVALID, 0, TAG_INVALID, 0, 0, 1'b0);
        @(negedge clk);
        check("t1_c1_valid", 80'(bus.wb_valid), 80'(0));
        @(negedge clk);
        check("t1_c2_valid", 80'(bus.wb_valid), 80'(1));
        @(negedge clk);
        check("t1_c3_valid", 80'(bus.wb_valid), 80'(0));
        drain("t1_drain");

        // all three sources at once
        do_flush();
        expq.push_back(mk(4'd1, 32'hA1, 1'b0, 32'h0));
        expq.push_back(mk(4'd2, 32'hB2, 1'b0, 32'h0));
        expq.push_back(mk(4'd5, 32'h104, 1'b1, 32'h200));
        cyc(4'd1, 32'hA1, 4'd2, 32'hB2, 4'd5, 32'h100, 32'h200, 1'b0);
        drain("t2_drain");

        // link value wraps
        do_flush();
        expq.push_back(mk(4'd6, 32'h0, 1'b1, 32'h8));
        cyc(TAG_INVALID, 0, TAG_INVALID, 0, 4'd6, 32'hFFFF_FFFC, 32'h8, 1'b0);
        drain("t_wrap_drain");

        // ALU/FWD alternate; alu_stall at count 3
        do_flush();
        for (int i = 0; i < 6; i++) begin
            expq.push_back(mk(4'(i), 32'h100 + i, 1'b0, 32'h0));
            expq.push_back(mk(4'(8 + i), 32'h200 + i, 1'b0, 32'h0));
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 4) check("t3_alu_stall_c4", 80'(bus.alu_stall), 80'(0));
            if (i == 5) check("t3_alu_stall_c5", 80'(bus.alu_stall), 80'(1));
            cyc(4'(i), 32'h100 + i, 4'(8 + i), 32'h200 + i,
                TAG_INVALID, 0, 0, 1'b0);
        end
        drain("t3_drain");

        // JMP overrun: 6th jump dropped
        do_flush();
        for (int k = 0; k < 5; k++) begin
            expq.push_back(mk(4'(k), 32'hA00 + k, 1'b0, 32'h0));
            expq.push_back(mk(4'(8 + k), 32'hF00 + k, 1'b0, 32'h0));
            expq.push_back(mk(4'(k + 1), 32'h1004 + 16 * k, 1'b1,
                              32'h2000 + k));
        end
        expq.push_back(mk(4'd5, 32'hA05, 1'b0, 32'h0));
        expq.push_back(mk(4'd13, 32'hF05, 1'b0, 32'h0));
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 5) begin
                check("t4_ovf_c5", 80'(bus.overflow), 80'(0));
                check("t4_jmp_stall_c5", 80'(bus.jmp_stall), 80'(1));
            end
            cyc(4'(k), 32'hA00 + k, 4'(8 + k), 32'hF00 + k,
                4'(k + 1), 32'h1000 + 16 * k, 32'h2000 + k, 1'b0);
        end
        @(negedge clk);
        check("t4_ovf_c6", 80'(bus.overflow), 80'(1));
        drain("t4_drain");
        check("t4_ovf_sticky", 80'(bus.overflow), 80'(1));

        // flush discards queued and same-cycle entries
        do_flush();
        check("t5_ovf_held", 80'(bus.overflow), 80'(1));
        expq.push_back(mk(4'd1, 32'h11, 1'b0, 32'h0));
        cyc(4'd1, 32'h11, 4'd2, 32'h22, 4'd4, 32'h300, 32'h400, 1'b0);
        cyc(TAG_INVALID, 0, TAG_INVALID, 0, TAG_INVALID, 0, 0, 1'b0);
        cyc(4'd7, 32'h77, TAG_INVALID, 0, TAG_INVALID, 0, 0, 1'b1);
        @(negedge clk);
        check("t5_valid", 80'(bus.wb_valid), 80'(0));
        check("t5_stalls",
              80'({bus.alu_stall, bus.fwd_stall, bus.jmp_stall}), 80'(0));
        check("t5_ovf", 80'(bus.overflow), 80'(1));
        repeat (5) @(negedge clk);
        drain("t5_drain");

        // reset mid-stream with full FIFOs
        do_flush();
        expq.push_back(mk(4'd2, 32'h500, 1'b0, 32'h0));
        expq.push_back(mk(4'd9, 32'h600, 1'b0, 32'h0));
        expq.push_back(mk(4'd12, 32'h4004, 1'b1, 32'h7000));
        expq.push_back(mk(4'd3, 32'h501, 1'b0, 32'h0));
        expq.push_back(mk(4'd10, 32'h601, 1'b0, 32'h0));
        for (int k = 0; k < 6; k++) begin
            cyc(4'(2 + k), 32'h500 + k, 4'(9 + k), 32'h600 + k,
                4'(12 - k), 32'h4000 + 16 * k, 32'h7000 + k, 1'b0);
        end
        @(negedge clk);
        check("t6_stalls_full",
              80'({bus.alu_stall, bus.fwd_stall, bus.jmp_stall}), 80'(7));
        check("t6_ovf_pre", 80'(bus.overflow), 80'(1));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_outs_reset("t6_after_rst");
        repeat (4) @(negedge clk);
        check("t6_queue_empty", 80'(expq.size()), 80'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
